dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 256-word data memory. Shares the memory between the core load/store path (port 0) and a loader/debug port (port 1) with round-robin arbitration. Each access is latched and driven onto the memory for exactly one cycle, and the result is returned with a done pulse. The memory keeps its synchronous write and combinational read; this block owns its MemWrite/MemRead/addr/writeData pins.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_if.sv | 29 ++
 rtl/dmem_arbiter_rr.sv | 17 +
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and sizing for the two-port data-memory arbiter
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_WORDS = 256;
  localparam logic [ADDR_W-1:0] MEM_BYTE_LIMIT = ADDR_W'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_RESP
  } arb_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < MEM_BYTE_LIMIT;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester port bundle and memory pin bundle for dmem_arbiter
interface dmem_port_if;
  import dmem_arb_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input gnt, done, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, done, rdata, err);
endinterface

interface dmem_mem_if;
  import dmem_arb_pkg::*;

  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output we, re, addr, wdata, input rdata);
  modport slave  (input we, re, addr, wdata, output rdata);
endinterface

// File: rtl/dmem_arbiter_rr.sv
// rtl/dmem_arbiter_rr.sv - two-way round-robin picker; ptr holds the port granted last
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b01 : 2'b10;
    end
    ptr_nxt = (|gnt) ? gnt[1] : ptr;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sequencer sharing the 256-word data memory between two ports
// Optional DMEM_ARB_BOUNDS_EN blocks and flags accesses at or above the memory's byte limit.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  dmem_port_if.slave m0,
  dmem_port_if.slave m1,
  dmem_mem_if.master mem
);

  arb_state_e state_q, state_d;
  logic ptr_q, ptr_d;
  logic port_q, port_d;
  logic we_q, we_d;
  logic blk_q, blk_d;
  logic mem_we_q, mem_we_d;
  logic mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [NUM_PORTS-1:0] req, arb_gnt, grant;
  logic arb_ptr;
  logic sel_port, sel_we, sel_blk;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign req = {m1.req, m0.req};

  rr_arbiter2 u_rr (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .ptr_nxt (arb_ptr)
  );

  // A new access can be accepted in IDLE and in RESP, never while the memory is busy.
  assign grant     = (state_q != ARB_ACCESS) ? arb_gnt : '0;
  assign sel_port  = grant[1];
  assign sel_we    = sel_port ? m1.we    : m0.we;
  assign sel_addr  = sel_port ? m1.addr  : m0.addr;
  assign sel_wdata = sel_port ? m1.wdata : m0.wdata;

`ifdef DMEM_ARB_BOUNDS_EN
  assign sel_blk = !addr_in_range(sel_addr);
`else
  assign sel_blk = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    port_d      = port_q;
    we_d        = we_q;
    blk_d       = blk_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    done_d      = '0;
    err_d       = '0;
    rdata_d     = '0;

    case (state_q)
      ARB_ACCESS: begin
        done_d[port_q]  = 1'b1;
        err_d[port_q]   = blk_q;
        rdata_d[port_q] = (we_q || blk_q) ? '0 : mem.rdata;
        state_d         = ARB_RESP;
      end
      default: begin
        if (|grant) begin
          port_d      = sel_port;
          we_d        = sel_we;
          blk_d       = sel_blk;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          mem_we_d    = sel_we && !sel_blk;
          mem_re_d    = !sel_we && !sel_blk;
          ptr_d       = arb_ptr;
          state_d     = ARB_ACCESS;
        end else begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  // Memory strobes are flops so they are high exactly in ACCESS and clear with reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= 1'b1;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      blk_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      port_q      <= port_d;
      we_q        <= we_d;
      blk_q       <= blk_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign m0.gnt   = grant[0];
  assign m1.gnt   = grant[1];
  assign m0.done  = done_q[0];
  assign m1.done  = done_q[1];
  assign m0.err   = err_q[0];
  assign m1.err   = err_q[1];
  assign m0.rdata = rdata_q[0];
  assign m1.rdata = rdata_q[1];

  assign mem.we    = mem_we_q;
  assign mem.re    = mem_re_q;
  assign mem.addr  = mem_addr_q;
  assign mem.wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized checks of dmem_arbiter against a transaction-level model
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

`ifdef DMEM_ARB_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_port_if p0 ();
  dmem_port_if p1 ();
  dmem_mem_if  mb ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (p0),
    .m1    (p1),
    .mem   (mb)
  );

  logic [31:0] dev_mem [MEM_WORDS];
  assign mb.rdata = dev_mem[mb.addr[9:2]];
  always @(posedge clk) if (mb.we) dev_mem[mb.addr[9:2]] <= mb.wdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: an accepted access occupies the memory the next cycle and answers the one after.
  typedef struct {
    bit          v;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          blk;
    logic [31:0] rd;
  } acc_t;

  acc_t h1, h2;
  bit mptr;
  logic [31:0] ref_mem [MEM_WORDS];
  int glog_port[$];
  int glog_cyc[$];
  int gcnt1 = 0, dcnt0 = 0, dcnt1 = 0;
  bit saw_we;

  function automatic bit blocked(input logic [31:0] a);
    return BOUNDS && (a >= 32'h400);
  endfunction

  always @(negedge clk) begin
    bit [1:0] eg, ed;
    bit ewe, ere, ee0, ee1;
    logic [31:0] er0, er1;
    acc_t n;
    if (mb.we) saw_we = 1'b1;
    if (p0.done) dcnt0++;
    if (p1.done) dcnt1++;
    if (p1.gnt) gcnt1++;
    if (p0.gnt) begin glog_port.push_back(0); glog_cyc.push_back(cyc); end
    if (p1.gnt) begin glog_port.push_back(1); glog_cyc.push_back(cyc); end
    if (!rst_n) begin
      h1.v = 1'b0;
      h2.v = 1'b0;
      mptr = 1'b1;
      chk("reset_outputs", {p0.gnt, p1.gnt, p0.done, p1.done, p0.err, p1.err, mb.we, mb.re,
                            |p0.rdata, |p1.rdata, |mb.addr, |mb.wdata}, 64'd0);
    end else begin
      eg = 2'b00;
      if (!h1.v) begin
        if (p0.req && p1.req) eg = mptr ? 2'b01 : 2'b10;
        else eg = {p1.req, p0.req};
      end
      ewe = 1'b0;
      ere = 1'b0;
      if (h1.v) begin
        ewe = h1.we && !h1.blk;
        ere = !h1.we && !h1.blk;
        h1.rd = (h1.we || h1.blk) ? 32'd0 : ref_mem[h1.addr[9:2]];
        if (ewe) ref_mem[h1.addr[9:2]] = h1.wdata;
        chk("mem_addr", mb.addr, h1.addr);
        chk("mem_wdata", mb.wdata, h1.wdata);
      end
      ed = 2'b00; er0 = 32'd0; er1 = 32'd0; ee0 = 1'b0; ee1 = 1'b0;
      if (h2.v) begin
        ed[h2.port] = 1'b1;
        if (h2.port) begin er1 = h2.rd; ee1 = h2.blk; end
        else begin er0 = h2.rd; ee0 = h2.blk; end
      end
      chk("gnt", {p1.gnt, p0.gnt}, eg);
      chk("mem_we_re", {mb.we, mb.re}, {ewe, ere});
      chk("done", {p1.done, p0.done}, ed);
      chk("rdata0", p0.rdata, er0);
      chk("rdata1", p1.rdata, er1);
      chk("err", {p1.err, p0.err}, {ee1, ee0});
      h2 = h1;
      n.v     = |eg;
      n.port  = eg[1];
      n.we    = eg[1] ? p1.we : p0.we;
      n.addr  = eg[1] ? p1.addr : p0.addr;
      n.wdata = eg[1] ? p1.wdata : p0.wdata;
      n.blk   = blocked(n.addr);
      n.rd    = 32'd0;
      if (|eg) mptr = eg[1];
      h1 = n;
    end
  end

  task automatic drive(input bit p, input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin p1.req = rq; p1.we = we; p1.addr = a; p1.wdata = d; end
    else   begin p0.req = rq; p0.we = we; p0.addr = a; p0.wdata = d; end
  endtask

  function automatic bit gnt_of(input bit p);
    return p ? p1.gnt : p0.gnt;
  endfunction

  function automatic bit done_of(input bit p);
    return p ? p1.done : p0.done;
  endfunction

  // patience below 20 means the master gives up (drops req) instead of reporting a timeout
  task automatic do_access(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                           input int patience, output logic [31:0] rd, output bit er,
                           output int gc, output int dc);
    int n;
    rd = 'x; er = 1'b0; gc = -1; dc = -1;
    @(posedge clk); #1; drive(p, 1'b1, we, a, d);
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt_of(p) || n >= patience) break;
      n++;
    end
    if (!gnt_of(p)) begin
      if (patience >= 20) chk("gnt_timeout", 64'd0, 64'd1);
      @(posedge clk); #1; drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
      return;
    end
    gc = cyc;
    @(posedge clk); #1; drive(p, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    n = 0;
    forever begin
      @(negedge clk);
      if (done_of(p) || n >= 5) break;
      n++;
    end
    if (!done_of(p)) begin
      chk("done_timeout", 64'd0, 64'd1);
      return;
    end
    dc = cyc;
    rd = p ? p1.rdata : p0.rdata;
    er = p ? p1.err : p0.err;
    chk("latency", 64'(dc - gc), 64'd2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    a = a | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 9) == 0) a = a | 32'h400;
    return a;
  endfunction

  task automatic rand_master(input bit p, input int count);
    logic [31:0] r;
    bit e;
    int g, d;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_access(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom,
                ($urandom_range(0, 7) == 0) ? 0 : 20, r, e, g, d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit er;
    int gc, dc, s0, s1;
    for (int i = 0; i < MEM_WORDS; i++) begin
      dev_mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_gnt", {p1.gnt, p0.gnt}, 64'd0);
    chk("idle_mem_addr", mb.addr, 64'd0);

    // single write then read on port 0
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 20, rd, er, gc, dc);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 20, rd, er, gc, dc);
    chk("wr_rd_rdata", rd, 64'hDEADBEEF);
    chk("wr_rd_err", er, 64'd0);

    // both ports requesting continuously from reset alternate starting with port 0
    do_reset();
    glog_port.delete();
    glog_cyc.delete();
    fork
      begin
        logic [31:0] r; bit e; int g, d;
        for (int i = 0; i < 3; i++) do_access(1'b0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, 20, r, e, g, d);
      end
      begin
        logic [31:0] r; bit e; int g, d;
        for (int i = 0; i < 3; i++) do_access(1'b1, 1'b0, 32'h200, 32'h0, 20, r, e, g, d);
      end
    join
    chk("alt_count", glog_port.size(), 64'd6);
    for (int i = 0; i < glog_port.size(); i++) chk("alt_port", glog_port[i], 64'(i % 2));
    for (int i = 1; i < glog_cyc.size(); i++) chk("alt_spacing", glog_cyc[i] - glog_cyc[i-1], 64'd2);

    // same-cycle conflict on 0x3FC: port 0 reads old value, then sees port 1's write
    do_reset();
    begin
      logic [31:0] r0, r1; bit e0, e1; int g0, g1, d0, d1;
      fork
        do_access(1'b0, 1'b0, 32'h3FC, 32'h0, 20, r0, e0, g0, d0);
        do_access(1'b1, 1'b1, 32'h3FC, 32'h12345678, 20, r1, e1, g1, d1);
      join
      chk("conflict_first_read", r0, 64'd0);
      chk("conflict_order", 64'(g1 - g0), 64'd2);
      do_access(1'b0, 1'b0, 32'h3FC, 32'h0, 20, r0, e0, g0, d0);
      chk("conflict_second_read", r0, 64'h12345678);
    end

    // write past the end of memory
    saw_we = 1'b0;
    do_access(1'b1, 1'b1, 32'h400, 32'hCAFEF00D, 20, rd, er, gc, dc);
    chk("bounds_err", er, 64'(BOUNDS));
    chk("bounds_mem_we_seen", saw_we, 64'(!BOUNDS));
    do_access(1'b0, 1'b0, 32'h000, 32'h0, 20, rd, er, gc, dc);
    chk("bounds_word0", rd, BOUNDS ? 64'd0 : 64'hCAFEF00D);

    // reset during the ACCESS cycle of a write to 0x20
    @(posedge clk); #1; drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(negedge clk);
    chk("rst_access_gnt", p0.gnt, 64'd1);
    @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_access_we_high", mb.we, 64'd1);
    s0 = dcnt0;
    #2 rst_n = 1'b0;
    #1 chk("rst_access_we_drop", mb.we, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_access_no_done", 64'(dcnt0 - s0), 64'd0);
    do_access(1'b0, 1'b0, 32'h20, 32'h0, 20, rd, er, gc, dc);
    chk("rst_access_word8", rd, 64'd0);

    // port 1 pulses req for one cycle while port 0's access is in flight
    s0 = gcnt1;
    s1 = dcnt1;
    @(posedge clk); #1; drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("drop_p0_gnt", p0.gnt, 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h40, 32'h55);
    @(posedge clk); #1; drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (4) @(negedge clk);
    chk("drop_p1_no_gnt", 64'(gcnt1 - s0), 64'd0);
    chk("drop_p1_no_done", 64'(dcnt1 - s1), 64'd0);

    // randomized traffic from both ports
    fork
      rand_master(1'b0, 80);
      rand_master(1'b1, 80);
    join
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
